// File: rtl/alu_multiciclo.sv
// Multicycle execute-stage ALU: single-cycle arithmetic/logic/compare ops, iterative
// one-bit-per-cycle shifts, and a START/BUSY/DONE handshake.
module alu_multiciclo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             START,
    input  logic [3:0]       ALU_SELECT,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpAnd  = 4'b0001;
    localparam logic [3:0] OpOr   = 4'b0010;
    localparam logic [3:0] OpSll  = 4'b0011;
    localparam logic [3:0] OpSlt  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpXor  = 4'b0111;
    localparam logic [3:0] OpSltu = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;

    localparam logic [SHW-1:0] CntOne = 1;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic [WIDTH-1:0] alu_res;
    logic             is_shift;
    logic             slt_bit;
    logic             sltu_bit;
    logic [WIDTH-1:0] acc_shifted;

    assign slt_bit  = $signed(A) < $signed(B);
    assign sltu_bit = A < B;
    assign is_shift = (ALU_SELECT == OpSll) || (ALU_SELECT == OpSrl) || (ALU_SELECT == OpSra);

    always_comb begin
        alu_res = '0;
        case (ALU_SELECT)
            OpAdd:   alu_res = A + B;
            OpAnd:   alu_res = A & B;
            OpOr:    alu_res = A | B;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OpSub:   alu_res = A - B;
            OpXor:   alu_res = A ^ B;
            OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
            default: alu_res = '0;
        endcase
    end

    // Only shift opcodes ever reach EXEC with a nonzero count.
    always_comb begin
        acc_shifted = acc_q;
        case (op_q)
            OpSll:   acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
            OpSrl:   acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
            OpSra:   acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_shifted = acc_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (START) begin
                        op_q    <= ALU_SELECT;
                        busy_q  <= 1'b1;
                        state_q <= StExec;
                        if (is_shift) begin
                            acc_q <= A;
                            cnt_q <= B[SHW-1:0];
                        end else begin
                            acc_q <= alu_res;
                            cnt_q <= '0;
                        end
                    end
                end
                StExec: begin
                    if (cnt_q != '0) begin
                        acc_q <= acc_shifted;
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        result_q <= acc_q;
                        zero_q   <= (acc_q == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign ZERO   = zero_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed scenarios followed by random operations
// compared against an arithmetic reference model.
module tb_alu_multiciclo;

    logic        CLK;
    logic        RST_n;
    logic        START;
    logic [3:0]  ALU_SELECT;
    logic [31:0] A;
    logic [31:0] B;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic        ZERO;

    int n_checks;
    int n_fail;
    logic [31:0] last_res;

    alu_multiciclo #(.WIDTH(32), .SHW(5)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .START      (START),
        .ALU_SELECT (ALU_SELECT),
        .A          (A),
        .B          (B),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .RESULT     (RESULT),
        .ZERO       (ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a & b;
            4'd2:    return a | b;
            4'd3:    return a << sh;
            4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:    return a >> sh;
            4'd6:    return a - b;
            4'd7:    return a ^ b;
            4'd8:    return (a < b) ? 32'd1 : 32'd0;
            4'd9:    return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] sel, input logic [31:0] b);
        if (sel == 4'd3 || sel == 4'd5 || sel == 4'd9) return 1 + int'(b % 32);
        return 1;
    endfunction

    // Caller is at a negedge; b2b=1 issues in the current (DONE) cycle. poke>0 pulses START
    // with junk operands at that many cycles after the accepting edge.
    task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b, input int poke);
        logic [31:0] exp;
        int          lat;
        int          exp_lat;
        exp     = ref_alu(sel, a, b);
        exp_lat = ref_lat(sel, b);
        if (!b2b) begin
            @(negedge CLK);
            check("done_single", {31'd0, DONE}, 32'd0);
        end
        START      = 1'b1;
        ALU_SELECT = sel;
        A          = a;
        B          = b;
        @(posedge CLK);
        #1;
        START      = 1'b0;
        A          = $urandom;
        B          = $urandom;
        ALU_SELECT = 4'($urandom_range(0, 15));
        @(negedge CLK);
        check("busy_after_start", {31'd0, BUSY}, 32'd1);
        lat = 0;
        for (int j = 1; j <= 40; j++) begin
            if (j == poke) START = 1'b1;
            @(negedge CLK);
            START = 1'b0;
            if (DONE) begin
                lat = j;
                break;
            end
            if (j < 3 || j == poke + 1) begin
                check("busy_exec", {31'd0, BUSY}, 32'd1);
                check("result_held", RESULT, last_res);
            end
        end
        if (lat == 0) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            check("latency", lat, exp_lat);
            check("result", RESULT, exp);
            check("zero", {31'd0, ZERO}, {31'd0, exp == 32'd0});
            check("busy_at_done", {31'd0, BUSY}, 32'd0);
        end
        last_res = exp;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        last_res   = 32'd0;
        RST_n      = 1'b0;
        START      = 1'b0;
        ALU_SELECT = 4'd0;
        A          = 32'd0;
        B          = 32'd0;
        repeat (2) @(negedge CLK);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_result", RESULT, 32'd0);
        check("rst_zero", {31'd0, ZERO}, 32'd1);
        RST_n = 1'b1;

        run_op(4'd0, 32'd5, 32'd7, 1'b0, 0);
        run_op(4'd6, 32'd3, 32'd3, 1'b0, 0);
        run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 1'b1, 0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1, 0);
        run_op(4'd3, 32'd1, 32'd4, 1'b0, 0);
        run_op(4'd5, 32'h8000_0000, 32'd0, 1'b0, 0);
        run_op(4'd9, 32'h8000_0000, 32'd31, 1'b0, 10);
        run_op(4'd15, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 0);

        // Asynchronous reset in the middle of a long shift.
        @(negedge CLK);
        START      = 1'b1;
        ALU_SELECT = 4'd3;
        A          = 32'd1;
        B          = 32'd20;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (6) @(posedge CLK);
        #2;
        RST_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, BUSY}, 32'd0);
        check("arst_result", RESULT, 32'd0);
        check("arst_zero", {31'd0, ZERO}, 32'd1);
        repeat (3) begin
            @(negedge CLK);
            check("arst_no_done", {31'd0, DONE}, 32'd0);
        end
        RST_n    = 1'b1;
        last_res = 32'd0;
        run_op(4'd0, 32'd2, 32'd2, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  sel;
            logic [31:0] a;
            logic [31:0] b;
            sel = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) a = b;
            run_op(sel, a, b, bit'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Multicycle execute-stage ALU that consumes the 4-bit ALU_SELECT code from ALU control plus the two operands.
- Single-cycle operations (arithmetic, logic, compare) complete in one EXEC cycle.
- Shifts are performed iteratively, one bit per cycle, to save area.
- A START/BUSY/DONE handshake lets the multicycle controller stall until the result is valid.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 5, shift-amount width; equals log2(WIDTH).

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_n  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- ALU_SELECT  input  4  operation code (encoding below).
- A  input  WIDTH  operand 1.
- B  input  WIDTH  operand 2; shift amount is B[SHW-1:0].
- BUSY  output  1  high while an operation is in EXEC.
- DONE  output  1  one-cycle pulse; RESULT/ZERO valid from this cycle on.
- RESULT  output  WIDTH  registered result; held until the next completion.
- ZERO  output  1  registered (RESULT == 0), updated together with RESULT.

Behaviour:
- Reset (RST_n low, asynchronous): state IDLE; BUSY=0, DONE=0, RESULT=0, ZERO=1; internal ACC=0, CNT=0.
- ALU_SELECT encoding:
  - 0000 ADD; 0001 AND; 0010 OR; 0011 SLL; 0100 SLT (signed); 0101 SRL; 0110 SUB; 0111 XOR; 1000 SLTU; 1001 SRA.
  - 1010-1111: illegal; RESULT=0.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no carry/overflow outputs. SLT/SLTU return zero-extended 1 or 0. SRA replicates A[WIDTH-1].
- States IDLE, EXEC.
- IDLE, START=1 at edge k:
  - Latch op, ACC, CNT. For shifts ACC=A and CNT=B[SHW-1:0]; otherwise ACC=computed result and CNT=0.
  - Go to EXEC; BUSY=1 after edge k.
- EXEC, each edge:
  - CNT!=0: shift ACC one bit in the latched direction; CNT=CNT-1.
  - CNT==0: RESULT=ACC, ZERO=(ACC==0), DONE=1 for one cycle, BUSY=0, go to IDLE.
- Latency: DONE follows edge k+1+N, where N = shift amount (0 for non-shift ops). Shift by 0 completes at k+1 with RESULT=A.
- START is ignored while BUSY=1. Operands and ALU_SELECT are don't-care after edge k (captured internally).
- Back-to-back: the DONE cycle is an IDLE cycle, so START=1 during DONE is accepted at that edge. No idle gap is required.
- DONE is never high for two consecutive cycles from the same operation.
- Reset mid-EXEC aborts the operation: no DONE, RESULT returns to 0, ZERO=1.
- RESULT and ZERO change only on completion or reset.

Test Plan:
- ADD A=5, B=7, START at edge k -> DONE pulse after k+1, RESULT=12, ZERO=0; BUSY high exactly one cycle.
- SUB A=3, B=3 -> RESULT=0, ZERO=1. Then SLT A=0xFFFFFFFF, B=1 issued back-to-back in the DONE cycle -> RESULT=1. Then SLTU with the same operands -> RESULT=0.
- SLL A=1, B=4 -> BUSY for 5 cycles, DONE after k+5, RESULT=16. SRL A=0x80000000, B=0 -> DONE after k+1, RESULT=0x80000000.
- SRA A=0x80000000, B=31 -> DONE after k+32, RESULT=0xFFFFFFFF. Pulse START with different operands at k+10 -> ignored, result unchanged.
- Illegal ALU_SELECT=1111, A=B=0xFFFF -> DONE after k+1, RESULT=0, ZERO=1.
- SLL A=1, B=20; assert RST_n=0 at k+6 asynchronously -> BUSY=0, RESULT=0, ZERO=1 immediately, no DONE. After release, ADD 2+2 -> RESULT=4.
